// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception controller bus: mfc0/mtc0 access plus M-stage trap signals.
// master = pipeline side, slave = CP0 side.
interface cp0_exc_ctrl_if;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] DOut;
  logic [31:0] EPCOut;
  logic [31:0] HandlerPC;
  logic        Req;

  modport master (
    output A, DIn, WE, VPC, BDIn,
    output ExcCodeIn, HWInt, EXLClr,
    input  DOut, EPCOut, HandlerPC, Req
  );

  modport slave (
    input  A, DIn, WE, VPC, BDIn,
    input  ExcCodeIn, HWInt, EXLClr,
    output DOut, EPCOut, HandlerPC, Req
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt responder at M stage (SR, Cause, EPC).
// Optional macro CP0_PRID_EN: A=15 reads PRID_VAL.
module cp0_exc_ctrl #(
`ifdef CP0_PRID_EN
  parameter logic [31:0] PRID_VAL = 32'h2024_0007,
`endif
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input logic clk,
  input logic reset,
  cp0_exc_ctrl_if.slave bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic int_req;
  logic exc_req;
  logic req;

  assign int_req = ie & ~exl & (|(bus.HWInt & im));
  assign exc_req = ~exl & (bus.ExcCodeIn != 5'd0);
  assign req     = ~reset & (int_req | exc_req);

  assign bus.Req       = req;
  assign bus.EPCOut    = epc;
  assign bus.HandlerPC = HANDLER_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.HWInt;
      if (req) begin
        // trap squashes any mtc0/eret of the victim
        exl      <= 1'b1;
        bd       <= bus.BDIn;
        exc_code <= int_req ? 5'd0 : bus.ExcCodeIn;
        epc      <= bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
      end else begin
        if (bus.EXLClr)
          exl <= 1'b0;
        if (bus.WE) begin
          case (bus.A)
            5'd12: begin
              im  <= bus.DIn[15:10];
              exl <= bus.DIn[1];
              ie  <= bus.DIn[0];
            end
            5'd14: epc <= bus.DIn;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    bus.DOut = '0;
    case (bus.A)
      5'd12: bus.DOut = {16'b0, im, 8'b0, exl, ie};
      5'd13: bus.DOut = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      5'd14: bus.DOut = epc;
`ifdef CP0_PRID_EN
      5'd15: bus.DOut = PRID_VAL;
`endif
      default: bus.DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: reset, traps, masking, priority, PRId.
// Inputs change on negedge; outputs checked just after.
module tb_cp0_exc_ctrl;
  logic clk;
  logic reset;
  int   nchk;
  int   nerr;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [31:0] exp,
                    input string tag);
    bus.A = a;
    #1;
    check(tag, bus.DOut, exp);
  endtask

  task automatic idle();
    bus.WE = 0;
    bus.EXLClr = 0;
    bus.ExcCodeIn = 0;
    bus.BDIn = 0;
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1;
    bus.A = 0;
    bus.DIn = 0;
    bus.WE = 0;
    bus.VPC = 32'h3000;
    bus.BDIn = 0;
    bus.ExcCodeIn = 5'd5;
    bus.HWInt = 0;
    bus.EXLClr = 0;
    #1;
    check("req_in_reset0", {31'b0, bus.Req}, 0);
    tick();
    check("req_in_reset1", {31'b0, bus.Req}, 0);
    tick();
    reset = 0;
    bus.ExcCodeIn = 0;
    rd(5'd12, 32'h0, "rst_sr");
    rd(5'd13, 32'h0, "rst_cause");
    rd(5'd14, 32'h0, "rst_epc");
    check("handler", bus.HandlerPC, 32'h0000_4180);

    // interrupt
    bus.A = 5'd12; bus.DIn = 32'h0000_0401; bus.WE = 1;
    tick();
    idle();
    rd(5'd12, 32'h0000_0401, "mtc0_sr");
    bus.HWInt = 6'b000001; bus.VPC = 32'h3010;
    #1;
    check("int_req", {31'b0, bus.Req}, 1);
    tick();
    rd(5'd12, 32'h0000_0403, "int_sr");
    rd(5'd13, 32'h0000_0400, "int_cause");
    rd(5'd14, 32'h0000_3010, "int_epc");
    check("int_epcout", bus.EPCOut, 32'h3010);
    check("int_req_drop", {31'b0, bus.Req}, 0);

    // eret then delay-slot exception
    bus.HWInt = 0; bus.EXLClr = 1;
    tick();
    idle();
    rd(5'd12, 32'h0000_0401, "eret_sr");
    bus.ExcCodeIn = 5'd4; bus.VPC = 32'h3024; bus.BDIn = 1;
    #1;
    check("bd_req", {31'b0, bus.Req}, 1);
    tick();
    idle();
    rd(5'd13, 32'h8000_0010, "bd_cause");
    rd(5'd14, 32'h0000_3020, "bd_epc");

    // masked while EXL=1
    bus.ExcCodeIn = 5'd10; bus.VPC = 32'h3050;
    #1;
    check("mask_req", {31'b0, bus.Req}, 0);
    tick();
    idle();
    rd(5'd13, 32'h8000_0010, "mask_cause");
    rd(5'd14, 32'h0000_3020, "mask_epc");
    bus.EXLClr = 1;
    tick();
    idle();
    rd(5'd12, 32'h0000_0401, "mask_clr_sr");

    // interrupt + exception + mtc0 EPC in one cycle
    bus.HWInt = 6'b000001; bus.ExcCodeIn = 5'd12;
    bus.VPC = 32'h3100; bus.A = 5'd14;
    bus.DIn = 32'h0000_dead; bus.WE = 1;
    #1;
    check("sim_req", {31'b0, bus.Req}, 1);
    tick();
    idle();
    rd(5'd13, 32'h0000_0400, "sim_cause");
    rd(5'd14, 32'h0000_3100, "sim_epc");

    // EPC wrap in a delay slot at PC 0
    bus.HWInt = 0; bus.EXLClr = 1;
    tick();
    idle();
    bus.ExcCodeIn = 5'd8; bus.VPC = 32'h0; bus.BDIn = 1;
    tick();
    idle();
    rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");
    rd(5'd13, 32'h8000_0020, "wrap_cause");

    // Cause not writable; SR only keeps IM/EXL/IE
    bus.A = 5'd13; bus.DIn = 32'hFFFF_FFFF; bus.WE = 1;
    tick();
    idle();
    rd(5'd13, 32'h8000_0020, "cause_ro");
    bus.A = 5'd12; bus.DIn = 32'hFFFF_FFFF; bus.WE = 1;
    tick();
    idle();
    rd(5'd12, 32'h0000_FC03, "sr_mask");
    bus.A = 5'd14; bus.DIn = 32'h1234_5678; bus.WE = 1;
    tick();
    idle();
    rd(5'd14, 32'h1234_5678, "mtc0_epc");

`ifdef CP0_PRID_EN
    rd(5'd15, 32'h2024_0007, "prid");
`else
    rd(5'd15, 32'h0, "prid");
`endif
    rd(5'd3, 32'h0, "unimpl");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Coprocessor-0 exception/interrupt responder for the pipelined MIPS core. It sits at the M stage.
- Collects the exception code, victim PC and branch-delay flag from the pipeline, and samples the 6 hardware interrupt lines.
- Decides whether to take a trap and drives Req, the redirect request consumed by the PC register and the pipeline flush logic.
- Also hosts the SR, Cause and EPC registers for mfc0/mtc0, and supplies EPC for eret.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception handler entry; output on HandlerPC.
- PRID_VAL, 32'h2024_0007, constant returned for PRId (only when CP0_PRID_EN is defined).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- A  input  5  CP0 register number for mfc0/mtc0.
- DIn  input  32  mtc0 write data.
- WE  input  1  mtc0 write enable.
- VPC  input  32  PC of the instruction in M (victim).
- BDIn  input  1  victim is in a branch delay slot.
- ExcCodeIn  input  5  exception code of the victim; 0 = none.
- HWInt  input  6  external interrupt lines, level-sensitive.
- EXLClr  input  1  eret in M; clears SR.EXL.
- DOut  output  32  mfc0 read data (combinational on A).
- EPCOut  output  32  current EPC register value (eret target).
- HandlerPC  output  32  constant HANDLER_ADDR.
- Req  output  1  take-trap request; combinational.

Behaviour:
- Registers:
  - SR(12): IM=[15:10], EXL=[1], IE=[0]; other bits read 0.
  - Cause(13): BD=[31], IP=[15:10], ExcCode=[6:2]; other bits 0.
  - EPC(14): full 32 bits.
  - Any other A reads 0.
- Reset: SR, Cause and EPC = 0; Req forced 0 while reset is high; DOut follows A over zeroed registers.
- Request logic (combinational):
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (ExcCodeIn != 0).
  - Req = ~reset & (IntReq | ExcReq).
- Interrupt priority: IntReq beats ExcReq; ExcCode is recorded as 0.
- On posedge with Req=1:
  - EXL <= 1.
  - BD <= BDIn.
  - ExcCode <= IntReq ? 0 : ExcCodeIn.
  - EPC <= BDIn ? VPC-4 : VPC, 32-bit wrap-around.
  - Req drops the next cycle because EXL=1.
- Cause.IP <= HWInt every cycle, unconditionally, including while EXL=1.
- mtc0 (WE=1, no Req):
  - A=12 writes only IM, EXL and IE.
  - A=14 writes EPC.
  - A=13 and others are ignored; Cause is not software-writable.
  - When Req=1 in the same cycle, the mtc0 write is dropped: the victim is squashed.
- EXLClr with Req=0: EXL <= 0 at posedge.
- EXLClr with Req=1: trap wins, EXL stays 1.
- Read timing:
  - DOut and EPCOut reflect register state before the edge; there is no write-through bypass.
  - A hazard unit stalls mtc0 EPC followed by eret.
- Exceptions while EXL=1 are ignored: no state change, Req=0.
- Timing: the trap takes effect in 0 cycles (Req same cycle); architectural state updates 1 cycle later.

Optional Feature:
- Macro: CP0_PRID_EN.
  - Defined: A=15 reads PRID_VAL; writes to 15 are ignored.
  - Undefined: A=15 reads 0 like any unimplemented register.

Test Plan:
- Reset: reset=1 for 2 cycles with ExcCodeIn=5 -> Req=0; after release, DOut at A=12/13/14 = 0.
- Interrupt:
  - Stimulus: mtc0 SR=32'h0000_0401; then HWInt=6'b000001, VPC=32'h3010, BDIn=0.
  - Response: Req=1 same cycle; next cycle SR=32'h0000_0403, Cause=32'h0000_0400, EPC=32'h3010, Req=0.
- Delay-slot exception:
  - Stimulus: ExcCodeIn=4, VPC=32'h3024, BDIn=1, HWInt=0.
  - Response: Req=1; next cycle Cause=32'h8000_0010, EPC=32'h3020.
- Masking:
  - EXL=1 then ExcCodeIn=10 -> Req=0, Cause/EPC unchanged.
  - Then EXLClr=1 -> SR.EXL=0 next cycle.
- Simultaneous events:
  - Stimulus: SR=32'h401, HWInt[0]=1, ExcCodeIn=12 and WE=1 (A=14, DIn=32'hdead) in one cycle.
  - Response: ExcCode=0, EPC=VPC (not 32'hdead).
- PRId:
  - With CP0_PRID_EN: A=15 -> 32'h2024_0007.
  - Without it: A=15 -> 0.
